// File: rtl/aileron_seq.sv
// Rate-limited aileron valve sequencer: ramps cur_ang one unit per STEP_CYCLES toward the commanded target.
// Optional post-ramp settle dwell is built only when AILSEQ_DWELL_EN is defined.
module aileron_seq #(
    parameter int STEP_CYCLES  = 4,
    parameter int DWELL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cmd_ang,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       center,
    output logic [3:0] cur_ang,
    output logic       v1e,
    output logic       v2e,
    output logic       v1d,
    output logic       v2d,
    output logic       busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RAMP   = 2'd1;
`ifdef AILSEQ_DWELL_EN
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
`endif
    localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

    generate
        if (STEP_CYCLES < 1 || STEP_CYCLES > 255 ||
            DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_param
            $error("aileron_seq: STEP_CYCLES and DWELL_CYCLES must be within 1..255");
        end
    endgenerate

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic signed [3:0] cur;
    logic signed [3:0] cur_nx;
    logic signed [3:0] tgt;
    logic signed [3:0] tgt_nx;
    logic signed [3:0] cmd_clamped;
    logic signed [3:0] goal;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nx;
    logic [3:0]        valves;
    logic              accept;
`ifdef AILSEQ_DWELL_EN
    logic [7:0]        dwell;
    logic [7:0]        dwell_nx;
`endif

    // Valve pattern {v1e, v2e, v1d, v2d} for a given angle.
    function automatic logic [3:0] valve_decode(input logic signed [3:0] a);
        if (a <= -4'sd4)
            return 4'b1100;
        else if (a < 4'sd0)
            return 4'b1000;
        else if (a == 4'sd0)
            return 4'b0000;
        else if (a <= 4'sd3)
            return 4'b0010;
        else
            return 4'b0011;
    endfunction

    // -8 has no mirror image in the valve range, so it is folded onto -7.
    assign cmd_clamped = (cmd_ang == 4'b1000) ? -4'sd7 : $signed(cmd_ang);
    assign goal        = center ? 4'sd0 : tgt;
    assign cmd_ready   = (state == IDLE) && !center;
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state != IDLE);
    assign cur_ang     = cur;
    assign {v1e, v2e, v1d, v2d} = valves;

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        tgt_nx   = center ? 4'sd0 : tgt;
        cnt_nx   = cnt;
`ifdef AILSEQ_DWELL_EN
        dwell_nx = dwell;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    tgt_nx   = cmd_clamped;
                    cnt_nx   = 8'd0;
                    state_nx = RAMP;
                end else if (center && cur != 4'sd0) begin
                    cnt_nx   = 8'd0;
                    state_nx = RAMP;
                end
            end
            RAMP: begin
                // Arrival is tested before stepping, so a no-move command costs one cycle.
                if (cur == goal) begin
                    cnt_nx = 8'd0;
`ifdef AILSEQ_DWELL_EN
                    dwell_nx = 8'd0;
                    state_nx = SETTLE;
`else
                    state_nx = IDLE;
`endif
                end else if (cnt == STEP_LAST) begin
                    cnt_nx = 8'd0;
                    cur_nx = (cur < goal) ? cur + 4'sd1 : cur - 4'sd1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
`ifdef AILSEQ_DWELL_EN
            SETTLE: begin
                if (center && cur != 4'sd0) begin
                    cnt_nx   = 8'd0;
                    state_nx = RAMP;
                end else if (dwell == DWELL_LAST) begin
                    state_nx = IDLE;
                end else begin
                    dwell_nx = dwell + 8'd1;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Valves decode the next angle so they change on the same edge as cur_ang.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur    <= 4'sd0;
            tgt    <= 4'sd0;
            cnt    <= 8'd0;
            valves <= 4'b0000;
        end else begin
            state  <= state_nx;
            cur    <= cur_nx;
            tgt    <= tgt_nx;
            cnt    <= cnt_nx;
            valves <= valve_decode(cur_nx);
        end
    end

`ifdef AILSEQ_DWELL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dwell <= 8'd0;
        else
            dwell <= dwell_nx;
    end
`endif

endmodule

// File: tb/tb_aileron_seq.sv
// Scoreboard bench for aileron_seq: every expected angle step is queued with its edge number when a command is driven.
module tb_aileron_seq;

    localparam int STEP  = 4;
    localparam int DWELL = 8;
`ifdef AILSEQ_DWELL_EN
    localparam int SETTLE_EXTRA = DWELL;
`else
    localparam int SETTLE_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cmd_ang = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       center = 1'b0;
    logic       cmd_ready;
    logic [3:0] cur_ang;
    logic       v1e, v2e, v1d, v2d;
    logic       busy;
    logic [3:0] valves_v;

    assign valves_v = {v1e, v2e, v1d, v2d};

    aileron_seq #(.STEP_CYCLES(STEP), .DWELL_CYCLES(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_ang(cmd_ang), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .center(center), .cur_ang(cur_ang),
        .v1e(v1e), .v2e(v2e), .v1d(v1d), .v2d(v2d), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step_edge;
        int ang;
    } step_t;

    step_t exp_q[$];
    int    cycle = 0;
    int    checks = 0;
    int    errors = 0;
    int    model_ang = 0;
    int    last_ang = 0;

    always @(posedge clk) cycle = cycle + 1;

    function automatic int decodeValves(input int a);
        if (a <= -4) return 12;
        if (a < 0)   return 8;
        if (a == 0)  return 0;
        if (a <= 3)  return 2;
        return 3;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    function automatic int curVal();
        return int'($signed(cur_ang));
    endfunction

    // Every change of cur_ang must match the head of the expected-step queue.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ang = 0;
        end else if (curVal() != last_ang) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_step", curVal(), last_ang);
            end else begin
                step_t e;
                e = exp_q.pop_front();
                checkOutput("step_edge", cycle, e.step_edge);
                checkOutput("step_ang", curVal(), e.ang);
                checkOutput("step_valves", int'(valves_v), decodeValves(e.ang));
            end
            last_ang = curVal();
        end
    end

    task automatic pushRamp(input int from, input int to, input int e0, output int last_edge);
        int a;
        int k;
        a = from;
        k = 0;
        while (a != to) begin
            a = (to > a) ? a + 1 : a - 1;
            k++;
            exp_q.push_back('{step_edge: e0 + k * STEP, ang: a});
        end
        last_edge = e0 + k * STEP;
    endtask

    task automatic waitReady(input int budget, output int seen);
        seen = -1;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready) begin
                seen = cycle;
                break;
            end
            @(negedge clk);
        end
        if (seen < 0) checkOutput("ready_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int ang);
        int tgt;
        int e0;
        int last_edge;
        int seen;
        waitReady(200, seen);
        cmd_ang   = ang[3:0];
        cmd_valid = 1'b1;
        e0  = cycle + 1;
        tgt = (ang == -8) ? -7 : ang;
        pushRamp(model_ang, tgt, e0, last_edge);
        model_ang = tgt;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("busy_after_accept", int'(busy), 1);
        checkOutput("ready_after_accept", int'(cmd_ready), 0);
        waitReady(20 * STEP + DWELL + 10, seen);
        checkOutput("ready_edge", seen, last_edge + 1 + SETTLE_EXTRA);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("final_ang", curVal(), tgt);
        checkOutput("final_valves", int'(valves_v), decodeValves(tgt));
    endtask

    task automatic centerRedirect();
        int e0;
        int e1;
        int last_edge;
        int seen;
        waitReady(200, seen);
        cmd_ang   = 4'd5;
        cmd_valid = 1'b1;
        e0 = cycle + 1;
        exp_q.push_back('{step_edge: e0 + 4,  ang: 1});
        exp_q.push_back('{step_edge: e0 + 8,  ang: 2});
        exp_q.push_back('{step_edge: e0 + 12, ang: 1});
        exp_q.push_back('{step_edge: e0 + 16, ang: 0});
        while (cycle < e0 + 9) @(negedge clk);
        checkOutput("ang_before_center", curVal(), 2);
        center = 1'b1;
        while (cycle < e0 + 20 + SETTLE_EXTRA) @(negedge clk);
        checkOutput("center_ready_low", int'(cmd_ready), 0);
        checkOutput("center_idle", int'(busy), 0);
        checkOutput("center_ang", curVal(), 0);
        checkOutput("center_queue", exp_q.size(), 0);
        center = 1'b0;
        #1;
        checkOutput("ready_after_center", int'(cmd_ready), 1);
        e1 = cycle + 1;
        pushRamp(0, 5, e1, last_edge);
        model_ang = 5;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("busy_after_center", int'(busy), 1);
        waitReady(20 * STEP + DWELL + 10, seen);
        checkOutput("ready_edge_center", seen, last_edge + 1 + SETTLE_EXTRA);
        checkOutput("queue_drained_center", exp_q.size(), 0);
    endtask

    task automatic asyncResetMidRamp();
        int e0;
        int last_edge;
        int seen;
        waitReady(200, seen);
        cmd_ang   = 4'(-6);
        cmd_valid = 1'b1;
        e0 = cycle + 1;
        pushRamp(model_ang, -6, e0, last_edge);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cycle < e0 + 9) @(negedge clk);
        checkOutput("ang_before_reset", curVal(), model_ang - 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ang", curVal(), 0);
        checkOutput("async_rst_valves", int'(valves_v), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_ready", int'(cmd_ready), 1);
        exp_q.delete();
        model_ang = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_ang", curVal(), 0);
        checkOutput("post_rst_busy", int'(busy), 0);
        checkOutput("post_rst_ready", int'(cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        #3;
        checkOutput("reset_ang", curVal(), 0);
        checkOutput("reset_valves", int'(valves_v), 0);
        checkOutput("reset_ready", int'(cmd_ready), 1);
        checkOutput("reset_busy", int'(busy), 0);
        center = 1'b1;
        #1;
        checkOutput("reset_ready_center", int'(cmd_ready), 0);
        center = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_ang", curVal(), 0);
        checkOutput("idle_ready", int'(cmd_ready), 1);
        checkOutput("idle_busy", int'(busy), 0);

        $display("[TB] ramp 0 -> 3");
        applyStimulus(3);
        $display("[TB] command equal to current angle");
        applyStimulus(3);
        applyStimulus(0);
        $display("[TB] command -8 clamps to -7");
        applyStimulus(-8);
        applyStimulus(0);
        $display("[TB] emergency centre during ramp");
        centerRedirect();
        $display("[TB] full-scale ramps");
        applyStimulus(7);
        applyStimulus(-7);
        $display("[TB] random commands");
        for (int i = 0; i < 6; i++) begin
            r = int'($urandom_range(0, 15)) - 8;
            applyStimulus(r);
        end
        $display("[TB] asynchronous reset mid-ramp");
        asyncResetMidRamp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
